// File: rtl/sbox_byte_feeder.sv
// sbox_byte_feeder: byte-serial masked SubBytes controller placed directly
// upstream of a two-share Sbox. The two shares travel in separate registers and
// are never combined here.
//
// Build option: SBOX_IN_PRECHARGE_EN
//   defined     - each fed byte is followed by a zero cycle on sbox_in, so FEED
//                 takes 32 slots and sbox_in is zero in every non-FEED cycle.
//   not defined - bytes are fed back-to-back (16 slots) and sbox_in holds the
//                 last fed byte outside FEED.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; state_out_* holds the last result
// FEED   | one slot per cycle on sbox_in, captures may already be running
// DRAIN  | feeding finished, waiting for the Sbox pipeline to empty
// DONE   | single-cycle completion pulse

module sbox_byte_feeder #(
    parameter int SBOX_LATENCY = 4,
    parameter int NUM_BYTES    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in_s0,
    input  logic [127:0] state_in_s1,
    output logic [15:0]  sbox_in,
    input  logic [15:0]  sbox_out,
    output logic         prng_en,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out_s0,
    output logic [127:0] state_out_s1
);

`ifdef SBOX_IN_PRECHARGE_EN
    localparam logic PRECHARGE = 1'b1;
`else
    localparam logic PRECHARGE = 1'b0;
`endif

    // A slot is one cycle on sbox_in; with precharge every other slot is a zero.
    localparam int         NSLOT     = PRECHARGE ? 2 * NUM_BYTES : NUM_BYTES;
    localparam logic [4:0] LAST_SLOT = 5'(NSLOT - 1);
    localparam logic [3:0] LAT_LOAD  = 4'(SBOX_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q,    state_d;
    logic [4:0]     feed_cnt_q, feed_cnt_d;
    logic [4:0]     cap_cnt_q,  cap_cnt_d;
    logic [3:0]     lat_cnt_q,  lat_cnt_d;
    logic [127:0]   sh_s0_q,    sh_s0_d;
    logic [127:0]   sh_s1_q,    sh_s1_d;
    logic [7:0]     in_s0_q,    in_s0_d;
    logic [7:0]     in_s1_q,    in_s1_d;
    logic [127:0]   out_s0_q,   out_s0_d;
    logic [127:0]   out_s1_q,   out_s1_d;

    // Next-state, feed sequencing and result capture.
    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        sh_s0_d    = sh_s0_q;
        sh_s1_d    = sh_s1_q;
        in_s0_d    = in_s0_q;
        in_s1_d    = in_s1_q;
        out_s0_d   = out_s0_q;
        out_s1_d   = out_s1_q;

        // Capture runs in FEED and DRAIN once the Sbox latency has elapsed;
        // slot cap_cnt_q is on sbox_out during the cycle this edge ends.
        if (state_q == S_FEED || state_q == S_DRAIN) begin
            if (lat_cnt_q != 4'd0) begin
                lat_cnt_d = lat_cnt_q - 4'd1;
            end else begin
                cap_cnt_d = cap_cnt_q + 5'd1;
                if (!PRECHARGE || !cap_cnt_q[0]) begin
                    out_s0_d = {out_s0_q[119:0], sbox_out[15:8]};
                    out_s1_d = {out_s1_q[119:0], sbox_out[7:0]};
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FEED;
                    feed_cnt_d = 5'd0;
                    cap_cnt_d  = 5'd0;
                    lat_cnt_d  = LAT_LOAD;
                    in_s0_d    = state_in_s0[127:120];
                    in_s1_d    = state_in_s1[127:120];
                    sh_s0_d    = {state_in_s0[119:0], 8'h00};
                    sh_s1_d    = {state_in_s1[119:0], 8'h00};
                end
            end
            S_FEED: begin
                if (feed_cnt_q == LAST_SLOT) begin
                    state_d = S_DRAIN;
                    if (PRECHARGE) begin
                        in_s0_d = 8'h00;
                        in_s1_d = 8'h00;
                    end
                end else begin
                    feed_cnt_d = feed_cnt_q + 5'd1;
                    if (PRECHARGE && !feed_cnt_q[0]) begin
                        in_s0_d = 8'h00;
                        in_s1_d = 8'h00;
                    end else begin
                        in_s0_d = sh_s0_q[127:120];
                        in_s1_d = sh_s1_q[127:120];
                        sh_s0_d = {sh_s0_q[119:0], 8'h00};
                        sh_s1_d = {sh_s1_q[119:0], 8'h00};
                    end
                end
            end
            S_DRAIN: begin
                if (lat_cnt_q == 4'd0 && cap_cnt_q == LAST_SLOT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and share registers; reset clears any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            feed_cnt_q <= 5'd0;
            cap_cnt_q  <= 5'd0;
            lat_cnt_q  <= 4'd0;
            sh_s0_q    <= '0;
            sh_s1_q    <= '0;
            in_s0_q    <= 8'h00;
            in_s1_q    <= 8'h00;
            out_s0_q   <= '0;
            out_s1_q   <= '0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            sh_s0_q    <= sh_s0_d;
            sh_s1_q    <= sh_s1_d;
            in_s0_q    <= in_s0_d;
            in_s1_q    <= in_s1_d;
            out_s0_q   <= out_s0_d;
            out_s1_q   <= out_s1_d;
        end
    end

    // Outputs come straight from registers so sbox_in never glitches.
    always_comb begin
        sbox_in      = {in_s0_q, in_s1_q};
        busy         = (state_q == S_FEED) || (state_q == S_DRAIN);
        prng_en      = busy;
        done         = (state_q == S_DONE);
        state_out_s0 = out_s0_q;
        state_out_s1 = out_s1_q;
    end

endmodule

// File: tb/tb_sbox_byte_feeder.sv
// Bench for sbox_byte_feeder: a masked two-share Sbox stand-in with a fixed
// pipeline latency, random states, and a reference built from GF(2^8)
// arithmetic. Honours SBOX_IN_PRECHARGE_EN the same way the design does.

module tb_sbox_byte_feeder;

    localparam int LAT = 4;
`ifdef SBOX_IN_PRECHARGE_EN
    localparam bit PRECH = 1'b1;
`else
    localparam bit PRECH = 1'b0;
`endif
    localparam int NSLOT = PRECH ? 32 : 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] state_in_s0;
    logic [127:0] state_in_s1;
    logic [15:0]  sbox_in;
    logic [15:0]  sbox_out;
    logic         prng_en;
    logic         busy;
    logic         done;
    logic [127:0] state_out_s0;
    logic [127:0] state_out_s1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox_tbl [0:255];
    logic [15:0]  pipe [0:LAT-1];
    logic [7:0]   mask_q;
    logic [7:0]   unsh;
    logic [127:0] last_out;

    sbox_byte_feeder #(.SBOX_LATENCY(LAT), .NUM_BYTES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .state_in_s0  (state_in_s0),
        .state_in_s1  (state_in_s1),
        .sbox_in      (sbox_in),
        .sbox_out     (sbox_out),
        .prng_en      (prng_en),
        .busy         (busy),
        .done         (done),
        .state_out_s0 (state_out_s0),
        .state_out_s1 (state_out_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    // FIPS-197 S-box from its definition: inverse (x^254) then affine map.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] xb;
            xb  = 8'(x);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
            if (x == 0) inv = 8'h00;
            sbox_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    end

    // Masked Sbox stand-in: output shares are re-randomised every cycle.
    assign unsh     = sbox_in[15:8] ^ sbox_in[7:0];
    assign sbox_out = pipe[LAT-1];
    always @(posedge clk) begin
        mask_q  <= 8'($urandom);
        pipe[0] <= {sbox_tbl[unsh] ^ mask_q, mask_q};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s0, input logic [127:0] s1);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_tbl[byte_of(s0, i) ^ byte_of(s1, i)];
        return r;
    endfunction

    function automatic logic [15:0] exp_in(input logic [127:0] s0, input logic [127:0] s1, input int c);
        int b;
        if (PRECH && c[0]) return 16'h0000;
        b = PRECH ? c / 2 : c;
        return {byte_of(s0, b), byte_of(s1, b)};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_sbox_in"}, 128'(sbox_in), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_prng"}, 128'(prng_en), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_out_s0"}, state_out_s0, 128'(0));
        chk({tag, "_out_s1"}, state_out_s1, 128'(0));
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic run_op(input logic [127:0] s0, input logic [127:0] s1,
                          input int rst_at, input bit spur);
        logic [127:0] want_u;
        int cyc;
        bit aborted;
        want_u = model(s0, s1);
        aborted = 1'b0;
        state_in_s0 = s0;
        state_in_s1 = s1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < NSLOT + LAT + 8) begin
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("midrst");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_idle_busy", 128'(busy), 128'(0));
                aborted = 1'b1;
                break;
            end
            if (spur) start = (cyc == 3 || cyc == 10);
            if (cyc < NSLOT) chk("sbox_in", 128'(sbox_in), 128'(exp_in(s0, s1, cyc)));
            chk("busy", 128'(busy), 128'(1));
            chk("prng_en", 128'(prng_en), 128'(1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) return;
        chk("done_lat", 128'(cyc), 128'(NSLOT + LAT));
        chk("busy_done", 128'(busy), 128'(0));
        chk("prng_done", 128'(prng_en), 128'(0));
        chk("result", state_out_s0 ^ state_out_s1, want_u);
        chk("sbox_in_rest", 128'(sbox_in),
            PRECH ? 128'(0) : 128'({byte_of(s0, 15), byte_of(s1, 15)}));
        last_out = state_out_s0 ^ state_out_s1;
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'(0));
        chk("prng_idle", 128'(prng_en), 128'(0));
        chk("result_hold", state_out_s0 ^ state_out_s1, want_u);
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            chk("idle_done", 128'(done), 128'(0));
            chk("idle_busy", 128'(busy), 128'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [127:0] u;
        logic [127:0] m;
        rst = 1'b1;
        start = 1'b0;
        state_in_s0 = '0;
        state_in_s1 = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // All-zero unshared state.
        run_op({16{8'hAA}}, {16{8'hAA}}, -1, 1'b0);
        chk("t1_all63", last_out, {16{8'h63}});
        idle_gap(3);

        // Known S-box points in the first four bytes.
        u = rnd128();
        u[127:96] = 32'h5300FF01;
        m = rnd128();
        run_op(u ^ m, m, -1, 1'b0);
        chk("t2_bytes", 128'(last_out[127:96]), 128'(32'hED63167C));
        idle_gap(2);

        // Starts during FEED are ignored.
        run_op(rnd128(), rnd128(), -1, 1'b1);
        idle_gap(4);

        // Reset while byte 7 is on sbox_in, then a clean run.
        run_op(rnd128(), rnd128(), PRECH ? 14 : 7, 1'b0);
        idle_gap(2);
        run_op(rnd128(), rnd128(), -1, 1'b0);

        // Back-to-back: second start in the IDLE cycle right after done.
        run_op(rnd128(), rnd128(), -1, 1'b0);
        run_op(rnd128(), rnd128(), -1, 1'b0);
        idle_gap(2);

        for (int t = 0; t < 4; t++) begin
            run_op(rnd128(), rnd128(), -1, 1'b0);
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
